// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared state encoding and constants for the pipeline hazard controller.
// Imported by pipeline_hazard_ctrl and load_use_detect.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Width needed to hold the larger of the two cycle counts (at least 1 bit).
  function automatic int ccnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between the ID instruction and a load in EX.
// Loads targeting x0 never stall; rs2 only matters when the opcode reads it.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  output logic       hazard
);

  assign hazard = id_valid & ex_memread & (ex_rd != REG_X0) &
                  ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing around ID/EX: load-use stall, branch flush, halt on invalid opcode.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
//  state | meaning
//  RUN   | normal issue; detects branch / invalid op / load-use hazard
//  STALL | front end held, ID/EX bubbled for the remaining stall cycles
//  FLUSH | IF/ID flushed, ID/EX bubbled for the remaining flush cycles
//  HALT  | core stopped on invalid opcode until reset
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             id_inv_op,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int CCNT_W = ccnt_width(STALL_CYCLES, FLUSH_CYCLES);
  localparam logic [CCNT_W-1:0] STALL_LOAD = CCNT_W'(STALL_CYCLES - 1);
  localparam logic [CCNT_W-1:0] FLUSH_LOAD = CCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CCNT_W-1:0] CCNT_ONE   = CCNT_W'(1);

  hz_state_t         state, state_nxt;
  logic [CCNT_W-1:0] ccnt, ccnt_nxt;
  logic              hazard;
  logic              stall_evt, flush_evt;

  load_use_detect u_detect (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .hazard      (hazard)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      ccnt  <= '0;
    end else begin
      state <= state_nxt;
      ccnt  <= ccnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ccnt_nxt    = ccnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    halted      = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;
    case (state)
      ST_RUN: begin
        if (ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_evt   = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = ST_FLUSH;
            ccnt_nxt  = FLUSH_LOAD;
          end
        end else if (id_inv_op && id_valid) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          state_nxt   = ST_HALT;
        end else if (hazard) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          stall_evt   = 1'b1;
          if (STALL_CYCLES > 1) begin
            state_nxt = ST_STALL;
            ccnt_nxt  = STALL_LOAD;
          end
        end
      end
      // EX holds a bubble here, so branch and hazard inputs are not meaningful.
      ST_STALL: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        stall_evt   = 1'b1;
        if (ccnt == CCNT_ONE) state_nxt = ST_RUN;
        else                  ccnt_nxt  = ccnt - CCNT_ONE;
      end
      ST_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (ex_branch_taken) begin
          flush_evt = 1'b1;
          ccnt_nxt  = FLUSH_LOAD;
        end else if (ccnt == CCNT_ONE) begin
          state_nxt = ST_RUN;
        end else begin
          ccnt_nxt  = ccnt - CCNT_ONE;
        end
      end
      ST_HALT: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        halted      = 1'b1;
      end
      default: state_nxt = ST_RUN;
    endcase
    // Hold the front end and present a NOP downstream for the whole reset window.
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      halted      = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = stall_evt ^ flush_evt;
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a default instance (1/1 cycles) and a
// STALL_CYCLES=3 / FLUSH_CYCLES=2 instance driven with shared inputs.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rs2, id_inv_op, ex_memread, ex_branch_taken;
  logic [4:0]  id_rs1, id_rs2, ex_rd;

  logic        a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_halted;
  logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_halted;
  logic [31:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;

  int total = 0;
  int bad   = 0;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, halted}
  localparam logic [4:0] NORM = 5'b11000;
  localparam logic [4:0] STL  = 5'b00010;
  localparam logic [4:0] BR   = 5'b11110;
  localparam logic [4:0] HLT  = 5'b00011;
  localparam logic [4:0] RST  = 5'b00110;

  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .id_inv_op(id_inv_op), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .pc_write(a_pc_write), .ifid_write(a_ifid_write),
    .ifid_flush(a_ifid_flush), .idex_bubble(a_idex_bubble), .halted(a_halted),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipeline_hazard_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .id_inv_op(id_inv_op), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .pc_write(b_pc_write), .ifid_write(b_ifid_write),
    .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble), .halted(b_halted),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  function automatic logic [31:0] cexp(input int n);
`ifdef HAZARD_PERF_CNT_EN
    return 32'(n);
`else
    return (n >= 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic set_in(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u2, input logic inv, input logic mr,
                        input logic [4:0] rd, input logic br);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_uses_rs2 = u2;
    id_inv_op = inv; ex_memread = mr; ex_rd = rd; ex_branch_taken = br;
  endtask

  task automatic idle();
    set_in(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic check_outs();
    exp_t       e;
    string      t;
    logic [4:0] oa, ob;
    e  = exp_q.pop_front();
    t  = tag_q.pop_front();
    oa = {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_bubble, a_halted};
    ob = {b_pc_write, b_ifid_write, b_ifid_flush, b_idex_bubble, b_halted};
    total++;
    assert (oa === e.a) else begin
      bad++;
      $error("FAIL %s dut_a outs got=%b exp=%b", t, oa, e.a);
    end
    total++;
    assert (ob === e.b) else begin
      bad++;
      $error("FAIL %s dut_b outs got=%b exp=%b", t, ob, e.b);
    end
  endtask

  // Inputs are already driven; queue expectations, compare at negedge, advance past posedge.
  task automatic step(input string tag, input logic [4:0] ea, input logic [4:0] eb);
    exp_t e;
    e.a = ea;
    e.b = eb;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check_outs();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_all_cnt(input string tag, input int sa, input int fa, input int sb, input int fb);
    chk_cnt({tag, "_stall_a"}, a_stall_cnt, cexp(sa));
    chk_cnt({tag, "_flush_a"}, a_flush_cnt, cexp(fa));
    chk_cnt({tag, "_stall_b"}, b_stall_cnt, cexp(sb));
    chk_cnt({tag, "_flush_b"}, b_flush_cnt, cexp(fb));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    step("reset", RST, RST);
    chk_all_cnt("rst_cnt", 0, 0, 0, 0);
    rst_n = 1'b1;
    step("run_idle", NORM, NORM);

    // load-use on rs1
    set_in(1'b1, 5'd5, 5'd2, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0);
    step("lu_rs1_det", STL, STL);
    idle();
    step("lu_rs1_s2", NORM, STL);
    step("lu_rs1_s3", NORM, STL);
    step("lu_rs1_done", NORM, NORM);

    // x0 load and unused rs2 never stall
    set_in(1'b1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0);
    step("x0_load", NORM, NORM);
    set_in(1'b1, 5'd3, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    step("rs2_unused", NORM, NORM);
    set_in(1'b0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0);
    step("id_invalid_slot", NORM, NORM);

    // load-use on rs2
    set_in(1'b1, 5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0);
    step("lu_rs2_det", STL, STL);
    idle();
    step("lu_rs2_s2", NORM, STL);
    step("lu_rs2_s3", NORM, STL);
    step("lu_rs2_done", NORM, NORM);
    chk_all_cnt("after_stalls", 2, 0, 6, 0);

    // branch wins over a simultaneous hazard
    set_in(1'b1, 5'd5, 5'd2, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
    step("br_hazard", BR, BR);
    idle();
    step("br_hazard_f2", NORM, BR);
    step("br_hazard_done", NORM, NORM);

    // back-to-back branches reload the flush count
    set_in(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    step("br_b2b_1", BR, BR);
    step("br_b2b_2", BR, BR);
    idle();
    step("br_b2b_f", NORM, BR);
    step("br_b2b_done", NORM, NORM);

    // branch wins over invalid opcode
    set_in(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);
    step("br_inv", BR, BR);
    idle();
    step("br_inv_f", NORM, BR);
    step("br_inv_done", NORM, NORM);
    chk_all_cnt("after_flush", 2, 4, 6, 4);

    set_in(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    step("inv_not_valid", NORM, NORM);

    // halt and hold for 20 cycles under assorted inputs
    set_in(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    step("inv_det", STL, STL);
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 5'd5, 5'd5, 1'b1, i[0], 1'b1, 5'd5, i[1]);
      step($sformatf("halt_%0d", i), HLT, HLT);
    end
    chk_all_cnt("halt_frozen", 2, 4, 6, 4);
    rst_n = 1'b0;
    idle();
    step("halt_reset", RST, RST);
    chk_all_cnt("halt_rst_cnt", 0, 0, 0, 0);
    rst_n = 1'b1;
    step("halt_release", NORM, NORM);

    // reset in the middle of a multi-cycle flush
    set_in(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    step("flush_enter", BR, BR);
    idle();
    rst_n = 1'b0;
    step("flush_reset", RST, RST);
    rst_n = 1'b1;
    step("flush_release", NORM, NORM);
    step("flush_release2", NORM, NORM);
    chk_all_cnt("final_cnt", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
